// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game-tick sequencer.
//   sched_state_t  - sequencer state encoding (IDLE, START, WAIT_COLL, SETTLE)
//   *_DEF          - default delay / width constants used by tick_scheduler
//   max_int        - elaboration-time helper for counter sizing
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_COLL = 2'd2,
        SETTLE    = 2'd3
    } sched_state_t;

    localparam int GO_DELAY_DEF       = 2;
    localparam int REDO_DELAY_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 4096;
    localparam int FRAME_W_DEF        = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: rising-edge detector with a registered history bit.
// Ports:
//   clk     in  - clock
//   reset_n in  - asynchronous active-low reset
//   d       in  - level input, same clock domain
//   rise    out - high while d is 1 and its previous sampled value was 0
// RESET_VAL sets the history bit at reset; 1 suppresses a false edge when
// d is already high as reset is released.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: per-frame game-tick sequencer.
// A rising tick starts a collision scan, waits for coll_done, then pulses
// phys_go and coll_redo at fixed offsets from the accepted done.
// Optional feature macro: TICK_SCHED_TIMEOUT_EN (collision-scan timeout).
// Ports:
//   clk        in  - system clock
//   reset_n    in  - asynchronous active-low reset
//   tick_in    in  - level tick source; rising edges start a sequence
//   enable     in  - gate for new ticks
//   coll_done  in  - collision scan complete (pulse or level)
//   clr_flags  in  - clears overrun/timeout (a same-cycle set wins)
//   coll_start out - one-cycle pulse, start collision scan
//   phys_go    out - one-cycle pulse, apply physics step
//   coll_redo  out - one-cycle pulse, request collision re-scan
//   busy       out - sequence in progress
//   frame_cnt  out - completed sequence count (wraps)
//   overrun    out - sticky, tick dropped while busy
//   timeout    out - sticky, collision scan never finished
//
// state     | meaning
// IDLE      | waiting for an enabled tick edge
// START     | issue coll_start
// WAIT_COLL | waiting for coll_done (optionally bounded)
// SETTLE    | counting out phys_go and coll_redo offsets
module tick_scheduler
    import game_pkg::*;
#(
    parameter int GO_DELAY       = GO_DELAY_DEF,
    parameter int REDO_DELAY     = REDO_DELAY_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FRAME_W        = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick_in,
    input  logic               enable,
    input  logic               coll_done,
    input  logic               clr_flags,
    output logic               coll_start,
    output logic               phys_go,
    output logic               coll_redo,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               overrun,
    output logic               timeout
);

    localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, REDO_DELAY)) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] GO_HIT   = CNT_W'(GO_DELAY - 1);
    localparam logic [CNT_W-1:0] REDO_HIT = CNT_W'(REDO_DELAY - 1);

    sched_state_t     state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             tick_edge;
    logic             start_nx, go_nx, redo_nx, frame_inc, overrun_set;
    logic             coll_start_q, phys_go_q, coll_redo_q, busy_q, overrun_q;
    logic [FRAME_W-1:0] frame_q;

    rise_detect #(.RESET_VAL(1'b1)) u_tick_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (tick_in),
        .rise    (tick_edge)
    );

`ifdef TICK_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_HIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_set;
    logic timeout_q;
`endif

    // saturate rather than wrap so a stuck scan cannot alias a terminal count
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        start_nx  = 1'b0;
        go_nx     = 1'b0;
        redo_nx   = 1'b0;
        frame_inc = 1'b0;
`ifdef TICK_SCHED_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (tick_edge && enable) begin
                    state_nx = START;
                end
            end
            START: begin
                start_nx = 1'b1;
                state_nx = WAIT_COLL;
                cnt_nx   = '0;
            end
            WAIT_COLL: begin
                if (coll_done) begin
                    state_nx = SETTLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
`ifdef TICK_SCHED_TIMEOUT_EN
                    if (cnt == TO_HIT) begin
                        state_nx    = IDLE;
                        timeout_set = 1'b1;
                    end
`endif
                end
            end
            SETTLE: begin
                cnt_nx = cnt_inc;
                if (cnt == GO_HIT) begin
                    go_nx = 1'b1;
                end
                if (cnt == REDO_HIT) begin
                    redo_nx   = 1'b1;
                    frame_inc = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign overrun_set = tick_edge & enable & (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            coll_start_q <= 1'b0;
            phys_go_q    <= 1'b0;
            coll_redo_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            coll_start_q <= start_nx;
            phys_go_q    <= go_nx;
            coll_redo_q  <= redo_nx;
            busy_q       <= (state != IDLE);
            if (frame_inc) begin
                frame_q <= frame_q + 1'b1;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clr_flags) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef TICK_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end else if (clr_flags) begin
            timeout_q <= 1'b0;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign coll_start = coll_start_q;
    assign phys_go    = phys_go_q;
    assign coll_redo  = coll_redo_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed bench for tick_scheduler (FRAME_W=4,
// TIMEOUT_CYCLES=16, default delays). Cycle n is the interval after the
// n-th rising clock edge; inputs are driven and outputs sampled on falling
// edges.
module tb_tick_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick_in;
    logic       enable;
    logic       coll_done;
    logic       clr_flags;
    logic       coll_start;
    logic       phys_go;
    logic       coll_redo;
    logic       busy;
    logic [3:0] frame_cnt;
    logic       overrun;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_start = 0, n_go = 0, n_redo = 0;
    int t_start = -1, t_go = -1, t_redo = -1;
    int exp_frame = 0;

    tick_scheduler #(
        .GO_DELAY       (2),
        .REDO_DELAY     (4),
        .TIMEOUT_CYCLES (16),
        .FRAME_W        (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_in    (tick_in),
        .enable     (enable),
        .coll_done  (coll_done),
        .clr_flags  (clr_flags),
        .coll_start (coll_start),
        .phys_go    (phys_go),
        .coll_redo  (coll_redo),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (coll_start) begin n_start++; t_start = cyc; end
        if (phys_go)    begin n_go++;    t_go    = cyc; end
        if (coll_redo)  begin n_redo++;  t_redo  = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves tick_in high; t is the cycle in which tick_in first reads 1
    task automatic tick_pulse(output int t);
        @(negedge clk) tick_in = 1'b0;
        @(negedge clk) tick_in = 1'b1;
        t = cyc;
    endtask

    task automatic done_pulse(output int m);
        @(negedge clk) coll_done = 1'b1;
        m = cyc;
        @(negedge clk) coll_done = 1'b0;
    endtask

    task automatic run_seq();
        int t, m;
        tick_pulse(t);
        step(4);
        done_pulse(m);
        step(7);
    endtask

    initial begin
        int t, t2, m, s;
        int b_start, b_go, b_redo;

        reset_n   = 1'b0;
        tick_in   = 1'b1;
        enable    = 1'b1;
        coll_done = 1'b0;
        clr_flags = 1'b0;

        // reset values, tick_in already high at release
        step(3);
        chk("rst_busy",    busy,       0);
        chk("rst_start",   coll_start, 0);
        chk("rst_frame",   frame_cnt,  0);
        chk("rst_overrun", overrun,    0);
        chk("rst_timeout", timeout,    0);
        reset_n = 1'b1;
        step(5);
        chk("no_start_at_release", n_start, 0);
        chk("idle_busy",           busy,    0);

        // first sequence: start latency, done+2 / done+4, busy fall
        tick_pulse(t);
        step(3);
        chk("start_count", n_start, 1);
        chk("start_cycle", t_start, t + 2);
        step(8);
        done_pulse(m);
        step(4);
        chk("busy_in_redo_cycle", busy, 1);
        step(1);
        chk("busy_after_redo", busy, 0);
        exp_frame = 1;
        chk("frame_0_to_1", frame_cnt, exp_frame);
        step(1);
        chk("go_cycle",   t_go,   m + 3);
        chk("redo_cycle", t_redo, m + 5);
        chk("go_count",   n_go,   1);
        chk("redo_count", n_redo, 1);

        // second tick during WAIT_COLL is dropped and flagged
        b_start = n_start;
        tick_pulse(t);
        step(3);
        tick_pulse(t2);
        step(2);
        chk("overrun_set",       overrun,           1);
        chk("no_second_start",   n_start - b_start, 1);
        done_pulse(m);
        step(7);
        exp_frame++;
        chk("frame_after_overrun", frame_cnt, exp_frame);
        @(negedge clk) clr_flags = 1'b1;
        @(negedge clk) clr_flags = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // set and clear in the same cycle: set wins; enable drop does not abort
        tick_pulse(t);
        step(3);
        @(negedge clk) tick_in = 1'b0;
        @(negedge clk) begin tick_in = 1'b1; clr_flags = 1'b1; end
        @(negedge clk) clr_flags = 1'b0;
        step(1);
        chk("set_beats_clear", overrun, 1);
        enable = 1'b0;
        done_pulse(m);
        step(7);
        exp_frame++;
        chk("enable_low_completes", frame_cnt, exp_frame);

        // ticks ignored with enable low
        b_start = n_start;
        tick_pulse(t);
        step(4);
        chk("disabled_no_start", n_start - b_start, 0);
        chk("disabled_busy",     busy,              0);
        @(negedge clk) begin clr_flags = 1'b1; enable = 1'b1; end
        @(negedge clk) clr_flags = 1'b0;
        chk("overrun_cleared2", overrun, 0);

        // coll_done held as a level: one phys_go, one coll_redo
        b_go   = n_go;
        b_redo = n_redo;
        tick_pulse(t);
        step(3);
        @(negedge clk) coll_done = 1'b1;
        step(20);
        coll_done = 1'b0;
        step(3);
        chk("level_go_once",   n_go - b_go,     1);
        chk("level_redo_once", n_redo - b_redo, 1);
        exp_frame++;
        chk("level_frame", frame_cnt, exp_frame);

        // collision scan that never completes
        b_go = n_go;
        tick_pulse(t);
        s = t + 2;
`ifdef TICK_SCHED_TIMEOUT_EN
        step(s + 15 - cyc);
        chk("timeout_not_yet", timeout, 0);
        chk("busy_waiting",    busy,    1);
        step(1);
        chk("timeout_set", timeout, 1);
        step(2);
        chk("timeout_idle",  busy,        0);
        chk("timeout_frame", frame_cnt,   exp_frame);
        chk("timeout_no_go", n_go - b_go, 0);
        @(negedge clk) clr_flags = 1'b1;
        @(negedge clk) clr_flags = 1'b0;
        chk("timeout_cleared", timeout, 0);
`else
        step(40);
        chk("wait_forever_busy", busy,    1);
        chk("timeout_tied_low",  timeout, 0);
        done_pulse(m);
        step(7);
        exp_frame++;
        chk("late_done_frame", frame_cnt, exp_frame);
`endif

        // 16 complete sequences with a 4-bit counter wrap through 15 -> 0
        for (int i = 0; i < 16; i++) begin
            run_seq();
            exp_frame = (exp_frame + 1) % 16;
            chk("wrap_frame", frame_cnt, exp_frame);
        end

        // reset in SETTLE truncates the sequence
        b_go    = n_go;
        b_start = n_start;
        tick_pulse(t);
        step(4);
        done_pulse(m);
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("midrst_busy",    busy,      0);
        chk("midrst_frame",   frame_cnt, 0);
        chk("midrst_overrun", overrun,   0);
        chk("midrst_go",      phys_go,   0);
        chk("midrst_redo",    coll_redo, 0);
        step(4);
        chk("midrst_no_go", n_go - b_go, 0);
        reset_n = 1'b1;
        step(4);
        chk("midrst_no_restart", n_start - b_start, 1);
        chk("midrst_idle",       busy,              0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
